// File: rtl/hazard_scoreboard_pkg.sv
// Shared core types for the hazard scoreboard: default widths, register index
// type and the per-register slot control bundle.
package hazard_scoreboard_pkg;

    localparam int SB_REG_AW = 5;
    localparam int SB_CNT_W  = 2;

    typedef logic [SB_REG_AW-1:0] reg_idx_t;

    // One decoded request per register slot; clr dominates, inc beats set on avail.
    typedef struct packed {
        logic clr;
        logic inc;
        logic dec;
        logic set;
    } slot_ctl_t;

endpackage

// File: rtl/sb_reg_slot.sv
// One tracked register: pending-write counter plus bypass-available bit.
// The avail bit exists only when SB_FWD_EN is defined; otherwise it reads 0.
module sb_reg_slot
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  slot_ctl_t        ctl,
    output logic [CNT_W-1:0] cnt,
    output logic             avail,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q;

    // A retire that coincides with a new issue to the same register nets to zero.
    assign underflow = !ctl.clr && ctl.dec && !ctl.inc && (cnt_q == '0);
    assign cnt       = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (ctl.clr)
            cnt_q <= '0;
        else if (ctl.inc && !ctl.dec)
            cnt_q <= cnt_q + CNT_W'(1);
        else if (ctl.dec && !ctl.inc && (cnt_q != '0))
            cnt_q <= cnt_q - CNT_W'(1);
    end

`ifdef SB_FWD_EN
    logic av_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            av_q <= 1'b0;
        else if (ctl.clr || ctl.inc)
            av_q <= 1'b0;
        else if (ctl.set)
            av_q <= 1'b1;
    end

    assign avail = av_q;
`else
    logic unused_set;
    assign unused_set = ctl.set;
    assign avail      = 1'b0;
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: per-register pending-write counters gate issue on
// RAW/WAW hazards; result bypass relaxes RAW stalls when SB_FWD_EN is defined.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = SB_REG_AW,
    parameter int CNT_W  = SB_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic [REG_AW-1:0]        iss_rs1,
    input  logic [REG_AW-1:0]        iss_rs2,
    input  logic                     iss_rs1_use,
    input  logic                     iss_rs2_use,
    input  logic [REG_AW-1:0]        iss_rd,
    input  logic                     iss_wen,
    input  logic                     wb_valid,
    input  logic [REG_AW-1:0]        wb_rd,
    input  logic                     flush,
    input  logic                     res_valid,
    input  logic [REG_AW-1:0]        res_rd,
    output logic                     fwd1,
    output logic                     fwd2,
    output logic [REG_AW+CNT_W-1:0]  inflight,
    output logic                     wb_err
);

    localparam int NREG = 2**REG_AW;
    localparam int IW   = REG_AW + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            avail;
    logic [NREG-1:0]            uf;

    logic          pend1, pend2, stall1, stall2, waw;
    logic          do_inc, do_dec, same_rd, inc_net, dec_net;
    logic [IW-1:0] inflight_q;
    logic          wb_err_q;

    // Register 0 is hardwired: never pending, never bypassed, never underflows.
    assign cnt[0]   = '0;
    assign avail[0] = 1'b0;
    assign uf[0]    = 1'b0;

    always_comb begin
        pend1     = iss_rs1_use && (iss_rs1 != '0) && (cnt[iss_rs1] != '0);
        pend2     = iss_rs2_use && (iss_rs2 != '0) && (cnt[iss_rs2] != '0);
        stall1    = pend1 && !avail[iss_rs1];
        stall2    = pend2 && !avail[iss_rs2];
        waw       = iss_wen && (iss_rd != '0) && (cnt[iss_rd] == CNT_MAX);
        iss_ready = !flush && !stall1 && !stall2 && !waw;
        fwd1      = iss_ready && pend1 && avail[iss_rs1];
        fwd2      = iss_ready && pend2 && avail[iss_rs2];
    end

    assign do_inc  = iss_valid && iss_ready && iss_wen && (iss_rd != '0);
    assign do_dec  = wb_valid && !flush && (wb_rd != '0);
    assign same_rd = (iss_rd == wb_rd);
    assign inc_net = do_inc && !(do_dec && same_rd);
    assign dec_net = do_dec && !(do_inc && same_rd) && (cnt[wb_rd] != '0);

    for (genvar g = 1; g < NREG; g++) begin : g_slot
        slot_ctl_t ctl;

        assign ctl = '{clr: flush,
                       inc: do_inc && (iss_rd == REG_AW'(g)),
                       dec: do_dec && (wb_rd == REG_AW'(g)),
                       set: res_valid && (res_rd == REG_AW'(g))};

        sb_reg_slot #(.CNT_W(CNT_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .ctl       (ctl),
            .cnt       (cnt[g]),
            .avail     (avail[g]),
            .underflow (uf[g])
        );
    end

    // Running total tracks the counter sum incrementally instead of an adder tree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            inflight_q <= '0;
        else if (flush)
            inflight_q <= '0;
        else
            inflight_q <= inflight_q + IW'(inc_net) - IW'(dec_net);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wb_err_q <= 1'b0;
        else if (|uf)
            wb_err_q <= 1'b1;
    end

    assign inflight = inflight_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table, reset
// corner sequence, then random traffic against a counting reference model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NREG = 2**SB_REG_AW;
    localparam int MAXC = 2**SB_CNT_W - 1;
`ifdef SB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic iss_valid, iss_ready, iss_rs1_use, iss_rs2_use, iss_wen;
    reg_idx_t iss_rs1, iss_rs2, iss_rd, wb_rd, res_rd;
    logic wb_valid, flush, res_valid, fwd1, fwd2, wb_err;
    logic [SB_REG_AW+SB_CNT_W-1:0] inflight;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rs1_use(iss_rs1_use), .iss_rs2_use(iss_rs2_use),
        .iss_rd(iss_rd), .iss_wen(iss_wen),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .flush(flush), .res_valid(res_valid), .res_rd(res_rd),
        .fwd1(fwd1), .fwd2(fwd2), .inflight(inflight), .wb_err(wb_err)
    );

    typedef struct {
        bit v; int rs1; bit u1; int rs2; bit u2; int rd; bit wen;
        bit wbv; int wbrd; bit fl; bit rv; int rrd;
        bit e_rdy; bit e_f1; int e_inf; bit e_err;
    } vec_t;

    vec_t tab[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: outstanding-write tally per register.
    int pend[NREG];
    bit av[NREG];
    bit merr;

    function automatic vec_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wen,
                                bit wbv, int wbrd, bit fl, bit rv, int rrd,
                                bit e_rdy, bit e_f1, int e_inf, bit e_err);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.wen = wen;
        t.wbv = wbv; t.wbrd = wbrd; t.fl = fl; t.rv = rv; t.rrd = rrd;
        t.e_rdy = e_rdy; t.e_f1 = e_f1; t.e_inf = e_inf; t.e_err = e_err;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t t);
        iss_valid = t.v; iss_rs1 = reg_idx_t'(t.rs1); iss_rs1_use = t.u1;
        iss_rs2 = reg_idx_t'(t.rs2); iss_rs2_use = t.u2;
        iss_rd = reg_idx_t'(t.rd); iss_wen = t.wen;
        wb_valid = t.wbv; wb_rd = reg_idx_t'(t.wbrd); flush = t.fl;
        res_valid = t.rv; res_rd = reg_idx_t'(t.rrd);
    endtask

    task automatic idle();
        apply(mk(0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit m_pending(int r);
        return (r != 0) && (pend[r] > 0);
    endfunction

    function automatic bit m_ready();
        bit s1, s2, w;
        s1 = iss_rs1_use && m_pending(int'(iss_rs1)) && !(FWD && av[iss_rs1]);
        s2 = iss_rs2_use && m_pending(int'(iss_rs2)) && !(FWD && av[iss_rs2]);
        w  = iss_wen && (iss_rd != 0) && (pend[iss_rd] == MAXC);
        return !flush && !s1 && !s2 && !w;
    endfunction

    function automatic bit m_fwd(int rs, bit u);
        return FWD && m_ready() && u && m_pending(rs) && av[rs];
    endfunction

    function automatic int m_inflight();
        int s = 0;
        for (int r = 0; r < NREG; r++) s += pend[r];
        return s;
    endfunction

    task automatic m_clear();
        for (int r = 0; r < NREG; r++) begin
            pend[r] = 0;
            av[r]   = 1'b0;
        end
    endtask

    task automatic m_update(input bit fire);
        bit inc, dec;
        if (flush) begin
            m_clear();
        end else begin
            inc = fire && iss_wen && (iss_rd != 0);
            dec = wb_valid && (wb_rd != 0);
            if (!(inc && dec && iss_rd == wb_rd)) begin
                if (inc) pend[iss_rd]++;
                if (dec) begin
                    if (pend[wb_rd] > 0) pend[wb_rd]--;
                    else merr = 1'b1;
                end
            end
            if (FWD && res_valid && res_rd != 0) av[res_rd] = 1'b1;
            if (inc) av[iss_rd] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fire;
        int r;

        // RAW stall / release
        tab.push_back(mk(1,0,0,0,0,5,1, 0,0,0,0,0, 1,0,1,0));
        tab.push_back(mk(1,5,1,0,0,0,0, 0,0,0,0,0, 0,0,1,0));
        tab.push_back(mk(1,5,1,0,0,0,0, 1,5,0,0,0, 0,0,0,0));
        tab.push_back(mk(1,5,1,0,0,0,0, 0,0,0,0,0, 1,0,0,0));
        // WAW saturation on rd=7
        tab.push_back(mk(1,0,0,0,0,7,1, 0,0,0,0,0, 1,0,1,0));
        tab.push_back(mk(1,0,0,0,0,7,1, 0,0,0,0,0, 1,0,2,0));
        tab.push_back(mk(1,0,0,0,0,7,1, 0,0,0,0,0, 1,0,3,0));
        tab.push_back(mk(1,0,0,0,0,7,1, 0,0,0,0,0, 0,0,3,0));
        tab.push_back(mk(1,0,0,0,0,7,1, 1,7,0,0,0, 0,0,2,0));
        tab.push_back(mk(1,0,0,0,0,7,1, 0,0,0,0,0, 1,0,3,0));
        tab.push_back(mk(0,0,0,0,0,0,0, 1,7,0,0,0, 1,0,2,0));
        tab.push_back(mk(0,0,0,0,0,0,0, 1,7,0,0,0, 1,0,1,0));
        tab.push_back(mk(0,0,0,0,0,0,0, 1,7,0,0,0, 1,0,0,0));
        // same-cycle issue and writeback on rd=3
        tab.push_back(mk(1,0,0,0,0,3,1, 0,0,0,0,0, 1,0,1,0));
        tab.push_back(mk(1,0,0,0,0,3,1, 1,3,0,0,0, 1,0,1,0));
        tab.push_back(mk(1,0,0,3,1,0,0, 0,0,0,0,0, 0,0,1,0));
        tab.push_back(mk(0,0,0,0,0,0,0, 1,3,0,0,0, 1,0,0,0));
        // bypass on rd=9
        tab.push_back(mk(1,0,0,0,0,9,1, 0,0,0,0,0, 1,0,1,0));
        tab.push_back(mk(0,0,0,0,0,0,0, 0,0,0,1,9, 1,0,1,0));
        tab.push_back(mk(1,9,1,0,0,0,0, 0,0,0,0,0, FWD,FWD,1,0));
        tab.push_back(mk(0,0,0,0,0,0,0, 1,9,0,0,0, 1,0,0,0));
        // fill, flush, stale writeback
        tab.push_back(mk(1,0,0,0,0,1,1, 0,0,0,0,0, 1,0,1,0));
        tab.push_back(mk(1,0,0,0,0,2,1, 0,0,0,0,0, 1,0,2,0));
        tab.push_back(mk(1,0,0,0,0,4,1, 0,0,0,0,0, 1,0,3,0));
        tab.push_back(mk(1,0,0,0,0,6,1, 0,0,0,0,0, 1,0,4,0));
        tab.push_back(mk(1,0,0,0,0,8,1, 1,1,1,0,0, 0,0,0,0));
        tab.push_back(mk(1,4,1,6,1,0,0, 0,0,0,0,0, 1,0,0,0));
        tab.push_back(mk(0,0,0,0,0,0,0, 1,4,0,0,0, 1,0,0,1));

        idle();
        rst = 1'b1;
        #12;
        chk("reset inflight", 32'(inflight), 0);
        chk("reset wb_err", 32'(wb_err), 0);
        chk("reset iss_ready", 32'(iss_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            apply(tab[i]);
            #1;
            chk($sformatf("vec%0d iss_ready", i), 32'(iss_ready), int'(tab[i].e_rdy));
            chk($sformatf("vec%0d fwd1", i), 32'(fwd1), int'(tab[i].e_f1));
            chk($sformatf("vec%0d fwd2", i), 32'(fwd2), 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d inflight", i), 32'(inflight), tab[i].e_inf);
            chk($sformatf("vec%0d wb_err", i), 32'(wb_err), int'(tab[i].e_err));
        end

        // asynchronous reset mid-stream with two pending writes
        @(negedge clk);
        apply(mk(1,0,0,0,0,10,1, 0,0,0,0,0, 0,0,0,0));
        @(negedge clk);
        apply(mk(1,0,0,0,0,11,1, 0,0,0,0,0, 0,0,0,0));
        @(posedge clk); #1;
        chk("pre-rst inflight", 32'(inflight), 2);
        @(negedge clk);
        apply(mk(0,10,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0));
        #1;
        chk("pre-rst rs1=10 stall", 32'(iss_ready), 0);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst inflight", 32'(inflight), 0);
        chk("async rst wb_err", 32'(wb_err), 0);
        chk("async rst iss_ready", 32'(iss_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1,10,1,0,0,12,1, 0,0,0,0,0, 0,0,0,0));
        #1;
        chk("post-rst iss_ready", 32'(iss_ready), 1);
        @(posedge clk); #1;
        chk("post-rst inflight", 32'(inflight), 1);
        @(negedge clk);
        apply(mk(0,0,0,0,0,0,0, 1,10,0,0,0, 0,0,0,0));
        @(posedge clk); #1;
        chk("stale wb wb_err", 32'(wb_err), 1);
        chk("stale wb inflight", 32'(inflight), 1);

        // randomized traffic against the model
        do_reset();
        m_clear();
        merr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            iss_valid   = $urandom_range(0, 3) != 0;
            iss_rs1     = reg_idx_t'($urandom_range(0, 7));
            iss_rs2     = reg_idx_t'($urandom_range(0, 7));
            iss_rs1_use = $urandom_range(0, 1);
            iss_rs2_use = $urandom_range(0, 1);
            iss_rd      = reg_idx_t'(($urandom_range(0, 15) == 0) ? $urandom_range(0, NREG-1)
                                                                  : $urandom_range(0, 7));
            iss_wen     = $urandom_range(0, 3) != 0;
            r           = $urandom_range(0, 7);
            wb_rd       = reg_idx_t'(r);
            wb_valid    = ($urandom_range(0, 1) == 1) &&
                          ((pend[r] > 0) || ($urandom_range(0, 63) == 0));
            flush       = $urandom_range(0, 63) == 0;
            res_valid   = $urandom_range(0, 2) == 0;
            res_rd      = reg_idx_t'($urandom_range(0, 7));
            #1;
            chk("rnd iss_ready", 32'(iss_ready), int'(m_ready()));
            chk("rnd fwd1", 32'(fwd1), int'(m_fwd(int'(iss_rs1), iss_rs1_use)));
            chk("rnd fwd2", 32'(fwd2), int'(m_fwd(int'(iss_rs2), iss_rs2_use)));
            fire = iss_valid && m_ready();
            @(posedge clk);
            m_update(fire);
            #1;
            chk("rnd inflight", 32'(inflight), m_inflight());
            chk("rnd wb_err", 32'(wb_err), int'(merr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
